// File: rtl/downsample_sys_ctrl.sv
// System sequencer for the downsampling core: boot, wait for completion, then stream the
// result window from data memory on a valid/ready port. `DSC_CHECKSUM_EN adds a checksum port.

module downsample_sys_ctrl #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 8,
    parameter int OUT_BASE    = 0,
    parameter int OUT_LEN     = 16384,
    parameter int TIMEOUT_CYC = 0,
    parameter int TO_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              power_on,
    input  logic              proc_status,
    output logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              err_timeout
`ifdef DSC_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int CNT_W = $clog2(OUT_LEN + 1);
    localparam logic [CNT_W-1:0]  LEN_C   = CNT_W'(OUT_LEN);
    localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(OUT_LEN - 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(OUT_BASE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOOT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              err_q, err_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] fifo_q [2];
    logic [DATA_W-1:0] fifo_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;
    logic              issue;
    logic              xfer;
    logic [2:0]        occ;

    assign m_valid     = (fifo_cnt_q != 2'd0);
    assign m_data      = fifo_q[rd_ptr_q];
    assign m_last      = m_valid && (out_cnt_q == LAST_C);
    assign xfer        = m_valid && m_ready;
    assign ext_addr    = BASE_C + ADDR_W'(rd_cnt_q);
    assign busy        = (state_q == S_BOOT) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign power_on    = busy;
    assign done        = (state_q == S_DONE);
    assign err_timeout = err_q;

    // Occupancy after this cycle's pop: counting the departing word lets a read issue
    // every cycle under full throughput while never overrunning the 2-entry buffer.
    assign occ = 3'(fifo_cnt_q) + 3'(rd_pend_q) - 3'(xfer);

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        out_cnt_d = out_cnt_q;
        to_cnt_d  = to_cnt_q;
        err_d     = err_q;
        issue     = 1'b0;

        case (state_q)
            S_IDLE: begin
                rd_cnt_d  = '0;
                out_cnt_d = '0;
                to_cnt_d  = '0;
                err_d     = 1'b0;
                if (start) state_d = S_BOOT;
            end
            S_BOOT: begin
                to_cnt_d = '0;
                if (!proc_status) state_d = S_RUN;
            end
            S_RUN: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (proc_status) begin
                    state_d = S_DRAIN;
                end else if ((TIMEOUT_CYC > 0) && (to_cnt_q == TO_LAST)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                issue = (rd_cnt_q < LEN_C) && (occ < 3'd2);
                if (issue) rd_cnt_d = rd_cnt_q + CNT_W'(1);
                if (xfer) begin
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                    if (out_cnt_q == LAST_C) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d   = S_BOOT;
                    rd_cnt_d  = '0;
                    out_cnt_d = '0;
                    to_cnt_d  = '0;
                    err_d     = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_pend_d  = issue;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + 2'(rd_pend_q) - 2'(xfer);
        if (rd_pend_q) begin
            fifo_d[wr_ptr_q] = ext_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (xfer) rd_ptr_d = ~rd_ptr_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
            rd_pend_q  <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            out_cnt_q  <= out_cnt_d;
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
            rd_pend_q  <= rd_pend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // NOTE: the two buffer entries are reset on purpose: m_data is read straight from them
    // and must be 0 out of reset; larger storage arrays would normally stay unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            fifo_q <= fifo_d;
        end
    end

`ifdef DSC_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (((state_q == S_IDLE) || (state_q == S_DONE)) && start) begin
            sum_d = '0;
        end else if (xfer) begin
            sum_d = sum_q + 16'(m_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_downsample_sys_ctrl.sv
// Scoreboard bench for downsample_sys_ctrl: directed jobs push expected words into a queue,
// an independent monitor pops and compares on every output transfer.

module tb_downsample_sys_ctrl;

    localparam int ADDR_W      = 19;
    localparam int DATA_W      = 8;
    localparam int OUT_BASE    = 'h100;
    localparam int OUT_LEN     = 4;
    localparam int TIMEOUT_CYC = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              proc_status = 1'b0;
    logic              m_ready = 1'b0;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_data = '0;
    logic [DATA_W-1:0] m_data;
    logic              power_on, m_valid, m_last, busy, done, err_timeout;
`ifdef DSC_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    downsample_sys_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_BASE(OUT_BASE),
        .OUT_LEN(OUT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .power_on(power_on),
        .proc_status(proc_status), .ext_addr(ext_addr), .ext_data(ext_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done), .err_timeout(err_timeout)
`ifdef DSC_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] data_tab [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    function automatic logic [7:0] mem_word(input logic [ADDR_W-1:0] a);
        int off;
        off = int'(a) - OUT_BASE;
        if (off >= 0 && off < 4) return data_tab[off];
        return 8'hEE;
    endfunction

    // Memory model: registered read, data valid one cycle after the address.
    always @(posedge clk) ext_data <= mem_word(ext_addr);

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor state (written only by the monitor process).
    int         xfer_n = 0;
    int         first_v = -1;
    int         last_x = -1;
    int         max_out = 0;
    bit         stalled = 0;
    bit         chk_done_next = 0;
    logic [7:0] hold_data;
    logic       hold_last;

    always @(negedge clk) begin
        int outstanding;
        exp_t e;
        if (!rst_n) begin
            xfer_n = 0; first_v = -1; last_x = -1; max_out = 0;
            stalled = 0; chk_done_next = 0;
        end else begin
            if (start && !busy) begin
                xfer_n = 0; first_v = -1; last_x = -1; max_out = 0;
            end
            if (chk_done_next) begin
                check("done_after_last", done, 1);
                check("power_off_after_last", power_on, 0);
                check("valid_off_after_last", m_valid, 0);
                chk_done_next = 0;
            end
            if (busy) begin
                outstanding = int'(ext_addr) - OUT_BASE - xfer_n;
                if (outstanding > max_out) max_out = outstanding;
            end
            if (m_valid) begin
                if (first_v < 0) first_v = cyc;
                if (stalled) begin
                    check("stall_data_stable", m_data, hold_data);
                    check("stall_last_stable", m_last, hold_last);
                end
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", m_data, e.data);
                        check("m_last", m_last, e.last);
                    end
                    xfer_n++;
                    last_x = cyc;
                    if (m_last) chk_done_next = 1;
                    stalled = 0;
                end else begin
                    stalled   = 1;
                    hold_data = m_data;
                    hold_last = m_last;
                end
            end else begin
                if (stalled) check("valid_dropped_in_stall", 0, 1);
                stalled = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_job();
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.data = data_tab[k];
            e.last = (k == 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        check(name, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, r, k;
        logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset values
        tick(2);
        check("rst_flags", {power_on, m_valid, m_last, busy, done, err_timeout}, 0);
        check("rst_mdata", m_data, 0);
        check("rst_addr", ext_addr, 'h100);
        rst_n = 1'b1;
        tick(1);

        // Basic job, zero-bubble streaming
        m_ready = 1'b1;
        push_job();
        pulse_start(s);
        check("basic_boot_power", power_on, 1);
        tick(s + 10 - cyc);
        proc_status = 1'b1;
        r = cyc;
        wait_done("basic_done", 40);
        check("basic_first_valid", first_v, r + 3);
        check("basic_back_to_back", last_x, r + 6);
        check("basic_count", xfer_n, 4);
        check("basic_power_off", power_on, 0);
`ifdef DSC_CHECKSUM_EN
        check("checksum", checksum, 16'h00AA);
`endif

        // Backpressure, with a start pulse mid-stream that must be ignored
        proc_status = 1'b0;
        push_job();
        pulse_start(s);
        tick(8);
        proc_status = 1'b1;
        k = 0;
        while (done !== 1'b1 && k < 80) begin
            m_ready = pat[k % 6];
            start   = (k == 5);
            tick(1);
            k++;
        end
        start   = 1'b0;
        m_ready = 1'b1;
        check("bp_done", done, 1);
        check("bp_count", xfer_n, 4);
        check("bp_outstanding_le2", max_out <= 2, 1);

        // Stale status: proc_status still 1 from the previous job
        push_job();
        pulse_start(s);
        tick(2);
        check("stale_in_boot", {busy, m_valid}, 2'b10);
        proc_status = 1'b0;
        tick(5);
        check("stale_no_early_data", first_v, -1);
        proc_status = 1'b1;
        r = cyc;
        wait_done("stale_done", 40);
        check("stale_first_valid", first_v, r + 3);

        // Timeout: proc_status never rises
        proc_status = 1'b0;
        pulse_start(s);
        tick(s + 21 - cyc);
        check("to_not_yet", done, 0);
        tick(1);
        check("to_done", done, 1);
        check("to_err", err_timeout, 1);
        check("to_no_valid", first_v, -1);

        // Restart clears err_timeout; status on the last RUN cycle wins over timeout
        push_job();
        pulse_start(s);
        check("to_err_cleared", err_timeout, 0);
        tick(s + 21 - cyc);
        proc_status = 1'b1;
        wait_done("edge_done", 40);
        check("edge_err", err_timeout, 0);
        check("edge_count", xfer_n, 4);

        // Reset during DRAIN after two words, then replay
        proc_status = 1'b0;
        push_job();
        pulse_start(s);
        tick(8);
        proc_status = 1'b1;
        k = 0;
        while (xfer_n < 2 && k < 40) begin
            tick(1);
            k++;
        end
        check("mid_two_words", xfer_n, 2);
        rst_n = 1'b0;
        proc_status = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_flags", {power_on, m_valid, m_last, busy, done, err_timeout}, 0);
        check("mid_rst_mdata", m_data, 0);
        check("mid_rst_addr", ext_addr, 'h100);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        push_job();
        pulse_start(s);
        tick(9);
        proc_status = 1'b1;
        wait_done("replay_done", 40);
        check("replay_count", xfer_n, 4);
        tick(2);
        check("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/downsample_sys_ctrl.md
Name: downsample_sys_ctrl

Overview:
- System sequencer for the image-downsampling core.
- Starts the processor and waits for its completion status.
- Then streams the result image out of data memory through the memory's external read port, on a valid/ready output stream.
- Successor to the bare top-level wiring: adds parametrised address/data widths, a result window, a processor timeout, and backpressure-safe readout.

Parameters:
- ADDR_W, 19, data-memory address width.
- DATA_W, 8, data-memory word width.
- OUT_BASE, 0, first data-memory address of the result image.
- OUT_LEN, 16384, number of result words to stream (≥1).
- TIMEOUT_CYC, 0, maximum RUN-state cycles before abort; 0 = no timeout.
- TO_W, 32, width of the timeout counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a job; ignored unless state is IDLE or DONE.
- power_on  out  1  drives processor_start of the core.
- proc_status  in  1  core status; 1 = job finished.
- ext_addr  out  ADDR_W  data-memory external read address.
- ext_data  in  DATA_W  data-memory external read data; valid exactly one cycle after ext_addr is presented.
- m_valid  out  1  output word valid.
- m_ready  in  1  sink accepts the word.
- m_data  out  DATA_W  output word.
- m_last  out  1  marks word OUT_LEN-1.
- busy  out  1  high in BOOT, RUN or DRAIN.
- done  out  1  high in DONE.
- err_timeout  out  1  sticky timeout flag.

Behaviour:
- **Clock and reset:** one clock, clk. Reset is asynchronous and active-low on rst_n.
- **Reset values:** all outputs 0, ext_addr = OUT_BASE, state IDLE, buffers empty, counters 0.
- **FSM states:** IDLE, BOOT, RUN, DRAIN, DONE.
- **IDLE:**
  - start → BOOT.
  - Clear err_timeout and the read/output counters.
- **BOOT:**
  - power_on = 1.
  - Stay until proc_status is sampled 0 (discards a stale done from a previous job), then → RUN.
- **RUN:**
  - power_on = 1.
  - proc_status sampled 1 → DRAIN.
  - If TIMEOUT_CYC > 0, a cycle counter runs. After TIMEOUT_CYC cycles in RUN: set err_timeout, → DONE; no data is streamed.
- **DRAIN:**
  - power_on stays 1.
  - Read side:
    - Issue address OUT_BASE + rd_cnt when rd_cnt < OUT_LEN and (buffered + in-flight) < 2.
    - The data returned one cycle later is written into a 2-entry FIFO.
    - Address arithmetic is modulo 2^ADDR_W.
  - Output side:
    - m_valid = FIFO not empty; m_data = FIFO head.
    - A transfer occurs when m_valid && m_ready.
    - m_data and m_last must hold stable while m_valid && !m_ready.
  - m_last = 1 on the transfer with out_cnt == OUT_LEN-1.
  - After that transfer: → DONE, same cycle FIFO empty.
- **Zero-bubble requirement:** with m_ready held 1, words stream one per cycle. The first m_valid is exactly 2 cycles after entering DRAIN.
- **DONE:**
  - power_on = 0; done = 1.
  - start → BOOT (new job; clears err_timeout and counters).
- **Simultaneous events:**
  - start while busy is ignored.
  - start in DONE takes priority over holding DONE.
  - The timeout and proc_status=1 on the same cycle → DRAIN (success wins).
- **Reset mid-operation:** immediate return to reset values. An in-flight memory read is discarded.
- **Status behaviour:** proc_status dropping to 0 during DRAIN has no effect.

Optional Feature:
- Macro: DSC_CHECKSUM_EN.
- When defined:
  - Adds output port checksum [15:0].
  - It is a running mod-2^16 sum of every transferred m_data, zero-extended.
  - Cleared on reset and on leaving IDLE/DONE.
  - Holds its final value in DONE.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic job (OUT_LEN=4, OUT_BASE=0x100, memory holds 0x11,0x22,0x33,0x44):
  - Stimulus: start, proc_status rises 10 cycles later, m_ready=1.
  - Required: ext_addr 0x100..0x103; m_data 0x11,0x22,0x33,0x44 on consecutive cycles; m_last on 0x44; done=1 the next cycle; power_on=0.
- Backpressure (same data, m_ready toggling 1,0,0,1,0,1…):
  - Required: no word lost or duplicated; m_data stable while stalled; at most 2 outstanding reads.
- Stale status:
  - Stimulus: proc_status held 1 at start, drops after 3 cycles, rises again after 5 more.
  - Required: stays in BOOT until the drop; DRAIN starts only after the second rise.
- Timeout (TIMEOUT_CYC=20, proc_status never rises):
  - Required: err_timeout=1 and done=1 after 20 RUN cycles; m_valid never asserted; a following start clears err_timeout.
- Reset during DRAIN (after 2 of 4 words):
  - Stimulus: rst_n low for 1 cycle.
  - Required: all outputs 0, state IDLE; a new start replays from word 0.
- DSC_CHECKSUM_EN build, basic job data:
  - Required: checksum = 0x00AA in DONE.
